// File: rtl/parking_gate_sequencer_pkg.sv
// Shared lane-state encoding, default sizing and the entry capacity rule for the gate sequencer.
package parking_gate_sequencer_pkg;

  typedef logic [1:0] lane_state_t;

  localparam lane_state_t StIdle   = 2'd0;
  localparam lane_state_t StWaitId = 2'd1;
  localparam lane_state_t StOpen   = 2'd2;
  // Entry lane only; the exit lane never refuses a vehicle.
  localparam lane_state_t StReject = 2'd3;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefIdTimeout      = 16;
  localparam int unsigned DefCntW           = 8;

  function automatic logic capacity_ok(input logic cls, input logic uni_free,
                                       input logic vis_free);
    return cls ? uni_free : vis_free;
  endfunction

endpackage

// File: rtl/loop_debounce.sv
// Loop sensor front end: 2-flop synchronizer, consecutive-sample filter and one-cycle
// rise/fall strobes that coincide with the first cycle of the new filtered level.
module loop_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_loop_raw,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_flip;

  assign w_differ = (r_sync2 != r_level);
  assign w_flip   = w_differ && (r_cnt == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_loop_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the filtered level restarts the run.
      if (!w_differ || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
      r_rise <= w_flip && !r_level;
      r_fall <= w_flip && r_level;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/parking_gate_sequencer.sv
// Entry/exit lane sequencer: pairs each debounced vehicle with a badge class, drives the
// barriers and emits one registered car_entered / car_exited pulse per passing vehicle.
module parking_gate_sequencer
  import parking_gate_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned ID_TIMEOUT      = DefIdTimeout,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic entry_loop_raw,
  input  logic entry_id_valid,
  input  logic entry_id_uni,
  input  logic exit_loop_raw,
  input  logic exit_id_valid,
  input  logic exit_id_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_barrier_open,
  output logic exit_barrier_open,
  output logic entry_full_lamp
);

  localparam logic [CNT_W-1:0] TimerLast = CNT_W'(ID_TIMEOUT - 1);

  logic w_en_rise;
  logic w_en_fall;
  logic w_ex_rise;
  logic w_ex_fall;

  loop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_entry_loop (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_loop_raw(entry_loop_raw),
    .o_rise    (w_en_rise),
    .o_fall    (w_en_fall)
  );

  loop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_exit_loop (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_loop_raw(exit_loop_raw),
    .o_rise    (w_ex_rise),
    .o_fall    (w_ex_fall)
  );

  // ---------------------------------------------------------------- entry lane
  lane_state_t      r_en_state;
  lane_state_t      w_en_state_nxt;
  logic [CNT_W-1:0] r_en_timer;
  logic [CNT_W-1:0] w_en_timer_nxt;
  logic             r_en_cls;
  logic             w_en_cls_nxt;
  logic             w_en_pulse;

  always_comb begin
    w_en_state_nxt = r_en_state;
    w_en_timer_nxt = r_en_timer;
    w_en_cls_nxt   = r_en_cls;
    w_en_pulse     = 1'b0;
    unique case (r_en_state)
      StIdle: begin
        if (w_en_rise) begin
          w_en_state_nxt = StWaitId;
          w_en_timer_nxt = '0;
          w_en_cls_nxt   = 1'b0;
        end
      end
      StWaitId: begin
        if (w_en_fall) begin
          w_en_state_nxt = StIdle;
        end else if (entry_id_valid) begin
          w_en_cls_nxt   = entry_id_uni;
          w_en_state_nxt = capacity_ok(entry_id_uni, uni_is_vacated_space, is_vacated_space)
                           ? StOpen : StReject;
        end else if (r_en_timer == TimerLast) begin
          w_en_cls_nxt   = 1'b0;
          w_en_state_nxt = capacity_ok(1'b0, uni_is_vacated_space, is_vacated_space)
                           ? StOpen : StReject;
        end else begin
          w_en_timer_nxt = r_en_timer + 1'b1;
        end
      end
      StOpen: begin
        if (w_en_fall) begin
          w_en_pulse     = 1'b1;
          w_en_state_nxt = StIdle;
        end
      end
      StReject: begin
        if (w_en_fall) begin
          w_en_state_nxt = StIdle;
        end
      end
      default: w_en_state_nxt = StIdle;
    endcase
  end

  logic r_car_entered;
  logic r_is_uni_entered;
  logic r_entry_barrier;
  logic r_entry_lamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_state       <= StIdle;
      r_en_timer       <= '0;
      r_en_cls         <= 1'b0;
      r_car_entered    <= 1'b0;
      r_is_uni_entered <= 1'b0;
      r_entry_barrier  <= 1'b0;
      r_entry_lamp     <= 1'b0;
    end else begin
      r_en_state       <= w_en_state_nxt;
      r_en_timer       <= w_en_timer_nxt;
      r_en_cls         <= w_en_cls_nxt;
      r_car_entered    <= w_en_pulse;
      r_is_uni_entered <= w_en_pulse & r_en_cls;
      r_entry_barrier  <= (w_en_state_nxt == StOpen);
      r_entry_lamp     <= (w_en_state_nxt == StReject);
    end
  end

  // ----------------------------------------------------------------- exit lane
  lane_state_t      r_ex_state;
  lane_state_t      w_ex_state_nxt;
  logic [CNT_W-1:0] r_ex_timer;
  logic [CNT_W-1:0] w_ex_timer_nxt;
  logic             r_ex_cls;
  logic             w_ex_cls_nxt;
  logic             w_ex_pulse;

  always_comb begin
    w_ex_state_nxt = r_ex_state;
    w_ex_timer_nxt = r_ex_timer;
    w_ex_cls_nxt   = r_ex_cls;
    w_ex_pulse     = 1'b0;
    unique case (r_ex_state)
      StIdle: begin
        if (w_ex_rise) begin
          w_ex_state_nxt = StWaitId;
          w_ex_timer_nxt = '0;
          w_ex_cls_nxt   = 1'b0;
        end
      end
      StWaitId: begin
        if (w_ex_fall) begin
          w_ex_state_nxt = StIdle;
        end else if (exit_id_valid) begin
          w_ex_cls_nxt   = exit_id_uni;
          w_ex_state_nxt = StOpen;
        end else if (r_ex_timer == TimerLast) begin
          w_ex_cls_nxt   = 1'b0;
          w_ex_state_nxt = StOpen;
        end else begin
          w_ex_timer_nxt = r_ex_timer + 1'b1;
        end
      end
      StOpen: begin
        if (w_ex_fall) begin
          w_ex_pulse     = 1'b1;
          w_ex_state_nxt = StIdle;
        end
      end
      default: w_ex_state_nxt = StIdle;
    endcase
  end

  logic r_car_exited;
  logic r_is_uni_exited;
  logic r_exit_barrier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_state      <= StIdle;
      r_ex_timer      <= '0;
      r_ex_cls        <= 1'b0;
      r_car_exited    <= 1'b0;
      r_is_uni_exited <= 1'b0;
      r_exit_barrier  <= 1'b0;
    end else begin
      r_ex_state      <= w_ex_state_nxt;
      r_ex_timer      <= w_ex_timer_nxt;
      r_ex_cls        <= w_ex_cls_nxt;
      r_car_exited    <= w_ex_pulse;
      r_is_uni_exited <= w_ex_pulse & r_ex_cls;
      r_exit_barrier  <= (w_ex_state_nxt == StOpen);
    end
  end

  assign car_entered        = r_car_entered;
  assign is_uni_car_entered = r_is_uni_entered;
  assign entry_barrier_open = r_entry_barrier;
  assign entry_full_lamp    = r_entry_lamp;
  assign car_exited         = r_car_exited;
  assign is_uni_car_exited  = r_is_uni_exited;
  assign exit_barrier_open  = r_exit_barrier;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Directed bench for parking_gate_sequencer: a visit-level lane model checked every cycle,
// plus literal timing/count expectations for each scenario.
module tb_parking_gate_sequencer;

  localparam int Deb   = 4;
  localparam int IdTmo = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic entry_loop_raw = 1'b0, entry_id_valid = 1'b0, entry_id_uni = 1'b0;
  logic exit_loop_raw = 1'b0, exit_id_valid = 1'b0, exit_id_uni = 1'b0;
  logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_barrier_open, exit_barrier_open, entry_full_lamp;

  always #5 clk = ~clk;

  parking_gate_sequencer #(
    .DEBOUNCE_CYCLES(Deb),
    .ID_TIMEOUT     (IdTmo),
    .CNT_W          (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .entry_loop_raw      (entry_loop_raw),
    .entry_id_valid      (entry_id_valid),
    .entry_id_uni        (entry_id_uni),
    .exit_loop_raw       (exit_loop_raw),
    .exit_id_valid       (exit_id_valid),
    .exit_id_uni         (exit_id_uni),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .entry_barrier_open  (entry_barrier_open),
    .exit_barrier_open   (exit_barrier_open),
    .entry_full_lamp     (entry_full_lamp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Visit-level model per lane (0 = entry, 1 = exit).
  logic [Deb+1:0] m_hist[2];
  bit m_lvl[2], m_rise[2], m_fall[2];
  bit m_in[2], m_clsd[2], m_grant[2], m_cls[2];
  int m_wait[2];
  bit e_pulse[2], e_uni[2];

  task automatic classify(input int l, input bit c);
    m_cls[l]  = c;
    m_grant[l] = (l == 0) ? (c ? uni_is_vacated_space : is_vacated_space) : 1'b1;
    m_clsd[l] = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        m_hist[l] = '0; m_lvl[l] = 0; m_rise[l] = 0; m_fall[l] = 0;
        m_in[l] = 0; m_clsd[l] = 0; m_grant[l] = 0; m_cls[l] = 0; m_wait[l] = 0;
        e_pulse[l] = 0; e_uni[l] = 0;
      end else begin
        bit raw, idv, idu, all_diff;
        raw = (l == 0) ? entry_loop_raw : exit_loop_raw;
        idv = (l == 0) ? entry_id_valid : exit_id_valid;
        idu = (l == 0) ? entry_id_uni : exit_id_uni;
        e_pulse[l] = 0;
        e_uni[l]   = 0;
        if (!m_in[l]) begin
          if (m_rise[l]) begin
            m_in[l] = 1; m_clsd[l] = 0; m_wait[l] = 0;
          end
        end else if (!m_clsd[l]) begin
          if (m_fall[l]) m_in[l] = 0;
          else if (idv) classify(l, idu);
          else if (m_wait[l] == IdTmo - 1) classify(l, 1'b0);
          else m_wait[l]++;
        end else if (m_fall[l]) begin
          e_pulse[l] = m_grant[l];
          e_uni[l]   = m_grant[l] & m_cls[l];
          m_in[l]    = 0;
        end
        // Filtered level moves once the last Deb synchronized samples all disagree with it.
        all_diff = 1;
        for (int i = 1; i <= Deb; i++) if (m_hist[l][i] == m_lvl[l]) all_diff = 0;
        m_rise[l] = all_diff && !m_lvl[l];
        m_fall[l] = all_diff && m_lvl[l];
        if (all_diff) m_lvl[l] = !m_lvl[l];
        m_hist[l] = {m_hist[l][Deb:0], raw};
      end
    end
  end

  // Observations used by the literal checks.
  int n_ent = 0, n_ext = 0, last_ent_cyc = -1, last_ext_cyc = -1, en_open_cyc = -1;
  int busy = 0;
  bit last_ent_uni = 0, last_ext_uni = 0, prev_bar = 0;

  always @(posedge clk) begin
    logic [6:0] act, exp_v;
    #2;
    if (rst_n) begin
      exp_v = {e_pulse[0], e_uni[0], e_pulse[1], e_uni[1],
               m_in[0] && m_clsd[0] && m_grant[0], m_in[1] && m_clsd[1],
               m_in[0] && m_clsd[0] && !m_grant[0]};
      act = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
             entry_barrier_open, exit_barrier_open, entry_full_lamp};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d got=%b want=%b", cyc, act, exp_v);
      end
      if (car_entered) begin n_ent++; last_ent_cyc = cyc; last_ent_uni = is_uni_car_entered; end
      if (car_exited)  begin n_ext++; last_ext_cyc = cyc; last_ext_uni = is_uni_car_exited;  end
      if (entry_barrier_open && !prev_bar) en_open_cyc = cyc;
      if (entry_barrier_open || entry_full_lamp || exit_barrier_open) busy++;
    end
    prev_bar = entry_barrier_open;
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n0, x0, t_badge, t_fall, t_rise, b0;

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    check("reset_outputs", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                            entry_barrier_open, exit_barrier_open, entry_full_lamp}, 0);
    rst_n = 1'b1;
    uni_is_vacated_space = 1'b1;
    is_vacated_space     = 1'b1;
    tick(2);

    // University entry with badge.
    n0 = n_ent;
    entry_loop_raw = 1; tick(12);
    entry_id_valid = 1; entry_id_uni = 1; t_badge = cyc; tick(1);
    entry_id_valid = 0; entry_id_uni = 0; tick(20);
    entry_loop_raw = 0; t_fall = cyc; tick(12);
    check("uni_open_latency", en_open_cyc - t_badge, 1);
    check("uni_pulse_latency", last_ent_cyc - t_fall, 7);
    check("uni_pulse_count", n_ent - n0, 1);
    check("uni_pulse_class", int'(last_ent_uni), 1);

    // No badge: visitor by timeout.
    n0 = n_ent;
    entry_loop_raw = 1; t_rise = cyc; tick(40);
    check("timeout_open_latency", en_open_cyc - t_rise, 23);
    entry_loop_raw = 0; tick(12);
    check("timeout_pulse_count", n_ent - n0, 1);
    check("timeout_pulse_class", int'(last_ent_uni), 0);

    // University class full: refused.
    uni_is_vacated_space = 0;
    n0 = n_ent;
    entry_loop_raw = 1; tick(12);
    entry_id_valid = 1; entry_id_uni = 1; tick(1);
    entry_id_valid = 0; entry_id_uni = 0; tick(5);
    check("full_lamp_on", int'(entry_full_lamp), 1);
    check("full_barrier_closed", int'(entry_barrier_open), 0);
    entry_loop_raw = 0; tick(12);
    check("full_lamp_cleared", int'(entry_full_lamp), 0);
    check("full_no_pulse", n_ent - n0, 0);
    uni_is_vacated_space = 1;

    // 3-cycle glitches ignored, then a 4-cycle level accepted.
    n0 = n_ent; b0 = busy;
    for (int g = 0; g < 4; g++) begin
      entry_loop_raw = 1; tick(3);
      entry_loop_raw = 0; tick(3);
    end
    tick(10);
    check("glitch_no_activity", busy - b0, 0);
    check("glitch_no_pulse", n_ent - n0, 0);
    entry_loop_raw = 1; t_rise = cyc; tick(4);
    entry_loop_raw = 0; tick(3);
    entry_loop_raw = 1; tick(30);
    check("four_cycle_accepted", en_open_cyc - t_rise, 23);
    entry_loop_raw = 0; tick(12);
    check("four_cycle_pulse_count", n_ent - n0, 1);

    // Both lanes clear in the same cycle.
    n0 = n_ent; x0 = n_ext;
    entry_loop_raw = 1; exit_loop_raw = 1; tick(10);
    entry_id_valid = 1; entry_id_uni = 1; exit_id_valid = 1; exit_id_uni = 0; tick(1);
    entry_id_valid = 0; entry_id_uni = 0; exit_id_valid = 0; tick(15);
    entry_loop_raw = 0; exit_loop_raw = 0; tick(12);
    check("simul_entry_count", n_ent - n0, 1);
    check("simul_exit_count", n_ext - x0, 1);
    check("simul_same_cycle", last_ent_cyc - last_ext_cyc, 0);
    check("simul_entry_class", int'(last_ent_uni), 1);
    check("simul_exit_class", int'(last_ext_uni), 0);

    // Reset while the entry barrier is open.
    n0 = n_ent;
    entry_loop_raw = 1; tick(10);
    entry_id_valid = 1; entry_id_uni = 1; tick(1);
    entry_id_valid = 0; entry_id_uni = 0; tick(5);
    check("pre_reset_open", int'(entry_barrier_open), 1);
    rst_n = 0; entry_loop_raw = 0;
    #1;
    check("reset_drops_barrier", int'(entry_barrier_open), 0);
    tick(3);
    rst_n = 1; tick(15);
    check("reset_no_pulse", n_ent - n0, 0);
    check("reset_barrier_idle", int'(entry_barrier_open), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
